// File: rtl/if_pkg.sv
// if_pkg: shared constants and types for the instruction fetch stage.
package if_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: small in-order {pc, instr} buffer, DEPTH 1 or 2, with synchronous clear.
module fetch_buf
    import if_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);
    localparam int W = $bits(fetch_entry_t);
    logic [DEPTH*W-1:0] mem;
    logic [1:0] cnt, wr_idx;
    assign wr_idx = cnt - {1'b0, pop};
    assign head = mem[W-1:0];
    assign empty = cnt == 2'd0;
    assign full = cnt == 2'(DEPTH);
    // entry 0 is always the oldest; a pop shifts the rest down
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            mem <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            mem <= pop ? mem >> W : mem;
            if (push) mem[int'(wr_idx)*W +: W] <= din;
        end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with one outstanding request and a fetch buffer.
// Define IF_PREFETCH_BUF_EN for a 2-entry prefetch buffer instead of a single holding register.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        reboot,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        isinstruct_IF
);
`ifdef IF_PREFETCH_BUF_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
    fetch_state_t state;
    fetch_entry_t head, rsp;
    logic [31:0] pc, rsp_pc, tgt;
    logic flush, fire, accept, buf_empty, buf_full;
    assign flush = redirect | reboot;
    assign tgt = reboot ? RST_PC : redirect_pc & ~32'h3;
    assign imem_req = state == REQ && !buf_full;
    assign imem_addr = pc;
    assign fire = imem_req & imem_gnt;
    assign accept = imem_rvalid && state == WAIT && !flush;
    assign rsp = '{pc: rsp_pc, instr: imem_rdata};

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (accept && (hold || !buf_empty)),
        .pop  (!flush && !hold && !buf_empty),
        .din  (rsp),
        .head (head),
        .empty(buf_empty),
        .full (buf_full)
    );

    // a grant coinciding with a redirect leaves a stale response to discard
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            pc <= RST_PC;
            rsp_pc <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: if (fire) state <= flush ? DROP : WAIT;
                WAIT: if (imem_rvalid) state <= REQ; else if (flush) state <= DROP;
                DROP: if (imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase
            pc <= flush ? tgt : fire ? pc + 32'd4 : pc;
            if (fire) rsp_pc <= pc;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            instr <= NOP_INSTR;
            pc_out <= '0;
            isinstruct_IF <= 1'b0;
        end else if (flush || (!hold && buf_empty && !accept)) begin
            instr <= NOP_INSTR;
            pc_out <= '0;
            isinstruct_IF <= 1'b0;
        end else if (!hold) begin
            instr <= buf_empty ? imem_rdata : head.instr;
            pc_out <= buf_empty ? rsp_pc : head.pc;
            isinstruct_IF <= 1'b1;
        end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a queue-based fetch model.
module tb_if_stage;
`ifdef IF_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0, rst = 1'b1;
    logic imem_req, imem_gnt = 0, imem_rvalid = 0, hold = 0, redirect = 0, reboot = 0, isinstruct_IF;
    logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, pc_out;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc), .reboot(reboot),
        .instr(instr), .pc_out(pc_out), .isinstruct_IF(isinstruct_IF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit live;
    } ent_t;

    ent_t pend[$];
    ent_t fbuf[$];
    bit m_started, m_v;
    logic [31:0] m_pc, m_out_pc, m_out_instr, fix_data, fix_pc;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    function automatic bit m_req();
        return m_started && pend.size() == 0 && fbuf.size() < DEPTH;
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_pc = RST_PC;
        pend.delete();
        fbuf.delete();
        m_v = 0;
        m_out_pc = 0;
        m_out_instr = NOP;
    endtask

    task automatic set_out(input bit v, input logic [31:0] p, input logic [31:0] d);
        m_v = v;
        m_out_pc = v ? p : 32'h0;
        m_out_instr = v ? d : NOP;
    endtask

    // applies one rising edge of the fetch rules to the model
    task automatic model_edge();
        bit flush = redirect | reboot;
        bit req = m_req();
        bit acc = 0;
        logic [31:0] tgt = reboot ? RST_PC : {redirect_pc[31:2], 2'b00};
        ent_t r;
        if (imem_rvalid && pend.size() > 0) begin
            r = pend.pop_front();
            acc = r.live && !flush;
        end
        if (flush) begin
            set_out(0, 0, 0);
            fbuf.delete();
            foreach (pend[i]) pend[i].live = 0;
        end else if (!hold) begin
            if (fbuf.size() > 0) begin
                r = acc ? r : r;
                set_out(1, fbuf[0].pc, fbuf[0].data);
                void'(fbuf.pop_front());
                if (acc) fbuf.push_back(r);
            end else if (acc) set_out(1, r.pc, r.data);
            else set_out(0, 0, 0);
        end else if (acc) fbuf.push_back(r);
        if (req && imem_gnt) begin
            pend.push_back('{m_pc, fix_data != 0 ? fix_data : word(m_pc), !flush});
            if (fix_data != 0) fix_pc = m_pc;
        end
        m_pc = flush ? tgt : (req && imem_gnt) ? m_pc + 32'd4 : m_pc;
        m_started = 1;
    endtask

    // entered at a falling edge; checks, drives, takes one rising edge, returns at the next falling edge
    task automatic step(input bit h, input bit rd, input logic [31:0] rpc, input bit rb, input bit g, input bit rv);
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        check("imem_addr", imem_addr, m_pc);
        check("isinstruct_IF", {31'b0, isinstruct_IF}, {31'b0, m_v});
        check("instr", instr, m_out_instr);
        check("pc_out", pc_out, m_out_pc);
        hold = h;
        redirect = rd;
        redirect_pc = rpc;
        reboot = rb;
        imem_gnt = g;
        imem_rvalid = rv && pend.size() > 0;
        imem_rdata = imem_rvalid ? pend[0].data : $urandom;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        fix_data = 0;
        fix_pc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_instr", instr, NOP);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_valid", {31'b0, isinstruct_IF}, 32'h0);
        rst = 0;
        // streaming fetch from reset
        step(0, 0, 0, 0, 1, 1);
        check("stream_addr0", imem_addr, 32'h0);
        step(0, 0, 0, 0, 1, 1);
        check("stream_addr4", imem_addr, 32'h4);
        step(0, 0, 0, 0, 1, 1);
        check("stream_first_valid", {31'b0, isinstruct_IF}, 32'h1);
        check("stream_first_pc", pc_out, 32'h0);
        check("stream_first_instr", instr, word(32'h0));
        repeat (10) step(0, 0, 0, 0, 1, 1);
        // response arriving under hold is buffered and released once
        drain();
        fix_data = 32'h00A0_0093;
        step(0, 0, 0, 0, 1, 0);
        fix_data = 0;
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("hold_frozen_valid", {31'b0, isinstruct_IF}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("hold_release_instr", instr, 32'h00A0_0093);
        check("hold_release_pc", pc_out, fix_pc);
        step(0, 0, 0, 0, 0, 0);
        check("hold_no_dup", {31'b0, isinstruct_IF}, 32'h0);
        // redirect while waiting drops the in-flight response
        drain();
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 32'h0000_0103, 0, 0, 0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_drop_req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        check("redir_dropped", {31'b0, isinstruct_IF}, 32'h0);
        check("redir_req", {31'b0, imem_req}, 32'h1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        check("redir_new_pc", pc_out, 32'h0000_0100);
        // reboot wins over simultaneous redirect
        drain();
        step(0, 1, 32'h0000_0500, 1, 0, 0);
        check("reboot_addr", imem_addr, RST_PC);
        check("reboot_req", {31'b0, imem_req}, 32'h1);
        // address wrap
        drain();
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        // asynchronous reset while a request is outstanding
        drain();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        imem_gnt = 0;
        imem_rvalid = 0;
        #2 rst = 1;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'h0);
        check("arst_addr", imem_addr, RST_PC);
        check("arst_instr", instr, NOP);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_valid", {31'b0, isinstruct_IF}, 32'h0);
        @(negedge clk);
        rst = 0;
        model_reset();
        step(0, 0, 0, 0, 1, 1);
        check("arst_restart", imem_addr, RST_PC);
        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
        step(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after rst or reboot.
REQ-002 clk  input  1  clock, rising edge active.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  fetch request valid.
REQ-005 imem_addr  output  32  fetch address, bits [1:0] always 0.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  fetch data valid, one per granted request, in order.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 hold  input  1  decode not accepting (data-memory or interrupt stall).
REQ-010 redirect  input  1  branch, jump or trap redirect this cycle.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 reboot  input  1  synchronous restart from RESET_PC.
REQ-013 instr  output  32  registered instruction to decode.
REQ-014 pc_out  output  32  registered address of instr.
REQ-015 isinstruct_IF  output  1  instr is a real fetched instruction, not a bubble.

Function
REQ-016 The fetch FSM SHALL have states IDLE, REQ, WAIT and DROP.
- IDLE->REQ: on the first clock after reset release.
- REQ->WAIT: on imem_req & imem_gnt.
- WAIT->REQ: on imem_rvalid.
- WAIT->DROP: on redirect or reboot without imem_rvalid.
- DROP->REQ: on imem_rvalid, with that data discarded.
REQ-017 imem_req SHALL be high only in REQ with a free buffer slot; imem_addr SHALL be the fetch PC and stay stable until grant unless a redirect occurs.
REQ-018 The fetch PC SHALL advance by 4 on each grant and wrap from 32'hFFFF_FFFC to 32'h0.
REQ-019 Each cycle with hold low, the output register SHALL load the oldest buffered word, else the word on imem_rvalid, else a bubble (instr = NOP 32'h0000_0013, pc_out = 0, isinstruct_IF = 0).
REQ-020 While hold is high, instr, pc_out and isinstruct_IF SHALL hold; a response arriving then SHALL go into fetch_buf.
REQ-021 Latency: imem_rvalid at cycle N with hold low and the buffer empty SHALL show on the outputs at N+1.
REQ-022 On redirect, regardless of hold, the block SHALL:
- load a bubble into the output register on the next edge;
- clear fetch_buf;
- set the fetch PC to {redirect_pc[31:2], 2'b00};
- assert imem_req for the new PC at N+1, unless in DROP.
REQ-023 A response arriving in the same cycle as redirect SHALL be discarded.
REQ-024 reboot SHALL act as a redirect to RESET_PC and SHALL take priority over a simultaneous redirect.

Reset
REQ-025 On rst, the block SHALL enter IDLE with:
- fetch PC = RESET_PC;
- fetch_buf empty;
- imem_req = 0 and imem_addr = RESET_PC;
- instr = NOP, pc_out = 0, isinstruct_IF = 0.
REQ-026 An rst asserted while a request is outstanding SHALL abandon that request; the memory side is reset by the same rst.

Configuration
REQ-027 With IF_PREFETCH_BUF_EN defined, fetch_buf SHALL be a 2-entry FIFO, and a request may issue while one entry is occupied, provided free slots exceed outstanding requests.
REQ-028 Without IF_PREFETCH_BUF_EN, fetch_buf SHALL be a single holding register, and requests SHALL issue only while it is empty.

Structure
REQ-029 Package if_pkg SHALL hold the NOP_INSTR constant, the fetch state enum and the RESET_PC default.
REQ-030 Sub-module fetch_buf SHALL hold the {pc, instr} pairs, with a DEPTH parameter (1 or 2) and a synchronous clear used on redirect and reboot.

Verification
REQ-031 Reset, then gnt and rvalid every cycle with hold low -> imem_addr 0, 4, 8...; first isinstruct_IF=1 with pc_out=0 one cycle after the first rvalid.
REQ-032 hold high for 3 cycles with rdata 32'h00A00093 arriving during hold -> outputs frozen; the word appears with its pc on the cycle after hold drops; no word lost or duplicated.
REQ-033 redirect to 32'h0000_0103 while in WAIT -> the next response is dropped; imem_addr = 32'h0000_0100; output is a bubble until the new response.
REQ-034 redirect and reboot in the same cycle with RESET_PC = 32'h0000_0000 -> next fetch at 0.
REQ-035 Fetch PC at 32'hFFFF_FFFC granted -> next imem_addr = 32'h0000_0000.
REQ-036 rst pulsed mid-WAIT -> all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
